// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: initial AddRoundKey on acceptance, then Nr
//   passes through an external single-round datapath, with the round result fed back.
// Latency: out_valid rises exactly Nr edges after the accepting edge; acceptances are
//   spaced at least Nr+2 edges apart. Backpressure: DONE holds out_valid/out_block
//   until out_ready. in_ready is high only in IDLE.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     plaintext handshake, in_block[0:127] (byte 0 at bits 0:7)
//   key_sched[0:KW-1]     expanded key words w[0..4Nr+3], stable while busy
//   out_valid/out_ready   ciphertext handshake, out_block[0:127] (zero outside DONE)
//   busy                  high in ROUND or DONE
//   blk_count             completed output handshakes, wraps silently
//   dp_state/dp_key/dp_final -> round datapath, dp_result <- its combinational output
module aes_round_sequencer #(
  parameter int Nk = 4,
  parameter int Nr = 10,
  parameter int CW = 16,
  localparam int KW = 32 * (4 * Nr + 4)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:127]  in_block,
  input  logic [0:KW-1] key_sched,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:127]  out_block,
  output logic          busy,
  output logic [CW-1:0] blk_count,
  output logic [0:127]  dp_state,
  output logic [0:127]  dp_key,
  output logic          dp_final,
  input  logic [0:127]  dp_result
);

  localparam int RW  = $clog2(Nr + 1);
  localparam int KIW = $clog2(KW);
  localparam logic [RW-1:0] NR_L = RW'(Nr);

  // Only the three standard AES key sizes are meaningful.
  generate
    if (!((Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) || (Nk == 8 && Nr == 14))) begin : g_bad_params
      $error("aes_round_sequencer: illegal Nk/Nr pair");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t           fsm;
  logic [0:127]   state;
  logic [RW-1:0]  rnd;
  logic [KIW-1:0] key_off;

  // Round key i starts at bit 128*i of the schedule.
  assign key_off = KIW'({rnd, 7'b0});

  assign dp_state  = state;
  assign dp_key    = (fsm == ROUND) ? key_sched[key_off +: 128] : '0;
  assign out_block = out_valid ? state : '0;

  // in_ready/out_valid/busy/dp_final are registered copies of FSM decode so they
  // change only on clock edges (or on reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state     <= '0;
      rnd       <= '0;
      blk_count <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      dp_final  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state    <= in_block ^ key_sched[0 +: 128];
            rnd      <= RW'(1);
            fsm      <= ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            dp_final <= (NR_L == RW'(1));
          end
        end
        ROUND: begin
          state <= dp_result;
          if (rnd == NR_L) begin
            fsm       <= DONE;
            rnd       <= '0;
            out_valid <= 1'b1;
            dp_final  <= 1'b0;
          end else begin
            rnd      <= rnd + RW'(1);
            // Assert dp_final for the cycle in which rnd will equal Nr.
            dp_final <= ((rnd + RW'(1)) == NR_L);
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            blk_count <= blk_count + CW'(1);
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          fsm       <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          dp_final  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Iterative AES encryption controller. It accepts one 128-bit block over a valid/ready handshake and applies the initial AddRoundKey. It then drives an external single-round combinational datapath for Nr cycles, feeding back its result and selecting the round key from the expanded key schedule. The final state is held on a valid/ready output port, replacing the fully unrolled cipher where area matters.

Parameters:
Nk, 4, key length in 32-bit words (4/6/8)
Nr, 10, number of rounds (10/12/14); legal pairs only: 4/10, 6/12, 8/14; an illegal pair is an elaboration error
KW, 32*(4*Nr+4), expanded key schedule width (localparam)
CW, 16, width of completed-block counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input block valid
in_ready  out  1  controller can accept a block
in_block  in  [0:127]  plaintext, byte 0 at bits 0:7, column-major
key_sched  in  [0:KW-1]  expanded key words w[0..4Nr+3]; must stay stable from acceptance until output handshake
out_valid  out  1  ciphertext valid
out_ready  in  1  consumer accepts ciphertext
out_block  out  [0:127]  ciphertext
busy  out  1  high in ROUND or DONE
blk_count  out  CW  completed output handshakes, wraps modulo 2^CW
dp_state  out  [0:127]  state to round datapath
dp_key  out  [0:127]  round key to round datapath
dp_final  out  1  datapath must skip MixColumns
dp_result  in  [0:127]  combinational round result from datapath

Behaviour:
- Registers:
  - state[0:127]
  - rnd counter, width $clog2(Nr+1)
  - FSM {IDLE, ROUND, DONE}
  - blk_count
- Reset (asynchronous, any time including mid-operation):
  - FSM=IDLE, state=0, rnd=0, blk_count=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, out_block=0, dp_key=0, dp_final=0, dp_state=0.
  - In-flight block is discarded; no out_valid is produced for it.
- IDLE:
  - in_ready=1.
  - On edge with in_valid=1: state <= in_block ^ key_sched[0+:128], rnd <= 1, go ROUND.
  - in_ready=0 in every other state; in_valid is ignored there.
- ROUND:
  - dp_state=state.
  - dp_key=key_sched[128*rnd +: 128].
  - dp_final=(rnd==Nr).
  - Each edge: state <= dp_result.
    - If rnd==Nr: go DONE, rnd <= 0.
    - Else: rnd <= rnd+1.
- In IDLE/DONE: dp_key=0, dp_final=0, dp_state=state.
- DONE:
  - out_valid=1, out_block=state.
  - Both are held stable until the edge with out_ready=1.
  - On that edge: go IDLE, blk_count <= blk_count+1.
  - out_block=0 outside DONE.
- Latency and throughput:
  - out_valid rises exactly Nr edges after the accepting edge.
  - There is no IDLE bypass: after the output handshake, in_ready=1 on the following cycle.
  - Minimum spacing between acceptances is Nr+2 edges.
- busy = FSM != IDLE; registered from FSM, no glitch.
- key_sched is not latched; a change while busy yields undefined ciphertext but the FSM timing is unaffected.
- blk_count wraps from 2^CW-1 to 0 without flag.

Test Plan:
1. Nk=4/Nr=10, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_valid exactly 10 edges after acceptance, out_block=69c4e0d86a7b0430d8cdb78070b4c55a, busy high throughout, blk_count=1.
2. Same block, out_ready held low 5 cycles after out_valid -> out_block and out_valid stable all 5 cycles, in_ready=0, a pulsed in_valid is not accepted; handshake on 6th cycle -> in_ready=1 next cycle.
3. Two blocks queued with in_valid held high and out_ready=1 -> second acceptance exactly 12 edges after first, both ciphertexts correct, blk_count=2.
4. Assert rst_n low during round 5 -> outputs take reset values immediately (asynchronous), no out_valid ever appears for that block; after release the vector from scenario 1 yields the correct result.
5. Nk=8/Nr=14, key 000102…1f, same pt -> out_block=8ea2b7ca516745bfeafc49904b496089 exactly 14 edges after acceptance.
6. Monitor dp_* during scenario 1 -> dp_key sequence equals w-blocks 1..10 in order, dp_final high for exactly one cycle (round 10), dp_key=0 in IDLE/DONE.
